// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline stage register with optional 2-entry skid
//            buffer, exception redirect and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int              PAYLOAD_W  = 256,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h00004180),
  parameter int              SKID       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_new_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_new_instr,
  output logic [1:0]           occupancy
);

  logic                 head_valid, skid_valid;
  logic [PC_W-1:0]      head_pc, skid_pc;
  logic [PAYLOAD_W-1:0] head_payload, skid_payload;
  logic                 head_ni, skid_ni;

  logic                 n_head_valid, n_skid_valid;
  logic [PC_W-1:0]      n_head_pc, n_skid_pc;
  logic [PAYLOAD_W-1:0] n_head_payload, n_skid_payload;
  logic                 n_head_ni, n_skid_ni;
  logic [1:0]           n_occupancy;

  logic accept;
  logic retire;

  // With the skid present, in_ready depends only on state so out_ready never
  // reaches in_ready combinationally.
  if (SKID != 0) begin : g_skid_ready
    assign in_ready = !skid_valid;
  end else begin : g_reg_ready
    assign in_ready = !head_valid || out_ready;
  end

  assign accept = in_valid && in_ready;
  assign retire = head_valid && out_ready;

  always_comb begin
    n_head_valid   = head_valid;
    n_head_pc      = head_pc;
    n_head_payload = head_payload;
    n_head_ni      = head_ni;
    n_skid_valid   = skid_valid;
    n_skid_pc      = skid_pc;
    n_skid_payload = skid_payload;
    n_skid_ni      = skid_ni;

    if (req) begin
      n_head_valid   = 1'b1;
      n_head_pc      = EXC_VECTOR;
      n_head_payload = '0;
      n_head_ni      = 1'b0;
      n_skid_valid   = 1'b0;
      n_skid_payload = '0;
      n_skid_ni      = 1'b0;
    end else if (flush) begin
      // out_pc deliberately keeps its value across a flush
      n_head_valid   = 1'b0;
      n_head_payload = '0;
      n_head_ni      = 1'b0;
      n_skid_valid   = 1'b0;
      n_skid_payload = '0;
      n_skid_ni      = 1'b0;
    end else if (skid_valid) begin
      if (retire) begin
        n_head_valid   = 1'b1;
        n_head_pc      = skid_pc;
        n_head_payload = skid_payload;
        n_head_ni      = skid_ni;
        n_skid_valid   = accept;
        n_skid_pc      = accept ? in_pc : skid_pc;
        n_skid_payload = accept ? in_payload : '0;
        n_skid_ni      = accept ? in_new_instr : 1'b0;
      end
    end else if (!head_valid || retire) begin
      if (accept) begin
        n_head_valid   = 1'b1;
        n_head_pc      = in_pc;
        n_head_payload = in_payload;
        n_head_ni      = in_new_instr;
      end else begin
        n_head_valid   = 1'b0;
        n_head_payload = '0;
        n_head_ni      = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      n_skid_valid   = 1'b1;
      n_skid_pc      = in_pc;
      n_skid_payload = in_payload;
      n_skid_ni      = in_new_instr;
    end

    n_occupancy = {1'b0, n_head_valid} + {1'b0, n_skid_valid};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid   <= 1'b0;
      head_pc      <= '0;
      head_payload <= '0;
      head_ni      <= 1'b0;
      skid_valid   <= 1'b0;
      skid_pc      <= '0;
      skid_payload <= '0;
      skid_ni      <= 1'b0;
      occupancy    <= 2'd0;
    end else begin
      head_valid   <= n_head_valid;
      head_pc      <= n_head_pc;
      head_payload <= n_head_payload;
      head_ni      <= n_head_ni;
      skid_valid   <= n_skid_valid;
      skid_pc      <= n_skid_pc;
      skid_payload <= n_skid_payload;
      skid_ni      <= n_skid_ni;
      occupancy    <= n_occupancy;
    end
  end

  assign out_valid     = head_valid;
  assign out_pc        = head_pc;
  assign out_payload   = head_payload;
  assign out_new_instr = head_ni;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg (SKID=1 and 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int PW = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_new_instr = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [PW-1:0] in_payload = '0;
  logic        in_ready, out_valid, out_new_instr;
  logic [31:0] out_pc;
  logic [PW-1:0] out_payload;
  logic [1:0]  occupancy;

  logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [31:0] in_pc0 = '0;
  logic [PW-1:0] in_payload0 = '0;
  logic        in_ready0, out_valid0, out_new_instr0;
  logic [31:0] out_pc0;
  logic [PW-1:0] out_payload0;
  logic [1:0]  occupancy0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(PW), .PC_W(32), .SKID(1)) dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_payload(in_payload), .in_new_instr(in_new_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_payload(out_payload), .out_new_instr(out_new_instr),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .PC_W(32), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .req(1'b0), .flush(1'b0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_pc(in_pc0),
    .in_payload(in_payload0), .in_new_instr(1'b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_pc(out_pc0),
    .out_payload(out_payload0), .out_new_instr(out_new_instr0),
    .occupancy(occupancy0)
  );

  function automatic logic [PW-1:0] pl(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    vectors++; if (out_payload !== '0 || out_new_instr !== 1'b0) begin miscompares++; $display("FAIL reset_payload got=%h/%b exp=0/0", out_payload, out_new_instr); end
    vectors++; if (occupancy !== 2'd0 || occupancy0 !== 2'd0) begin miscompares++; $display("FAIL reset_occ got=%0d/%0d exp=0/0", occupancy, occupancy0); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h3000 + 32'(4 * i);
      in_valid = 1'b1; in_pc = pc; in_payload = pl(pc); in_new_instr = i[0];
      step();
      vectors++; if (out_valid !== 1'b1 || out_pc !== pc) begin miscompares++; $display("FAIL stream_pc[%0d] got=%b/%h exp=1/%h", i, out_valid, out_pc, pc); end
      vectors++; if (out_payload !== pl(pc) || out_new_instr !== i[0]) begin miscompares++; $display("FAIL stream_payload[%0d] got=%h exp=%h", i, out_payload, pl(pc)); end
      vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
    end
    in_valid = 1'b0; in_new_instr = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_payload !== '0) begin miscompares++; $display("FAIL stream_drain got=%b/%0d/%h exp=0/0/0", out_valid, occupancy, out_payload); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3000; in_payload = pl(32'h3000); in_new_instr = 1'b0;
    step();
    in_pc = 32'h3004; in_payload = pl(32'h3004); in_new_instr = 1'b1;
    step();
    in_valid = 1'b0; in_new_instr = 1'b0;
    vectors++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready); end
    step();
    vectors++; if (out_pc !== 32'h3000 || occupancy !== 2'd2 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold got pc=%h occ=%0d rdy=%b exp pc=3000 occ=2 rdy=0", out_pc, occupancy, in_ready); end
    vectors++; if (out_payload !== pl(32'h3000)) begin miscompares++; $display("FAIL bp_hold_payload got=%h exp=%h", out_payload, pl(32'h3000)); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h3004 || out_new_instr !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release1 got v=%b pc=%h ni=%b occ=%0d rdy=%b exp 1/3004/1/1/1", out_valid, out_pc, out_new_instr, occupancy, in_ready); end
    vectors++; if (out_payload !== pl(32'h3004)) begin miscompares++; $display("FAIL bp_release1_payload got=%h exp=%h", out_payload, pl(32'h3004)); end
    step();
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL bp_release2 got v=%b occ=%0d exp 0/0", out_valid, occupancy); end
  endtask

  task automatic test_exception();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3010; in_payload = pl(32'h3010); in_new_instr = 1'b1;
    step();
    in_pc = 32'h3014; in_payload = pl(32'h3014);
    req = 1'b1;
    step();
    req = 1'b0; in_valid = 1'b0; in_new_instr = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h00004180) begin miscompares++; $display("FAIL exc_pc got v=%b pc=%h exp 1/00004180", out_valid, out_pc); end
    vectors++; if (out_payload !== '0 || out_new_instr !== 1'b0 || occupancy !== 2'd1) begin miscompares++; $display("FAIL exc_fields got pl=%h ni=%b occ=%0d exp 0/0/1", out_payload, out_new_instr, occupancy); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL exc_drain got v=%b occ=%0d exp 0/0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3020; in_payload = pl(32'h3020);
    step();
    in_pc = 32'h3024; in_payload = pl(32'h3024);
    step();
    in_pc = 32'h3028; in_payload = pl(32'h3028);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL flush_clear got v=%b occ=%0d exp 0/0", out_valid, occupancy); end
    vectors++; if (out_pc !== 32'h3020 || in_ready !== 1'b1 || out_payload !== '0) begin miscompares++; $display("FAIL flush_pc got pc=%h rdy=%b pl=%h exp 3020/1/0", out_pc, in_ready, out_payload); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3030; in_payload = pl(32'h3030);
    step();
    in_valid = 1'b0;
    req = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h00004180 || occupancy !== 2'd1) begin miscompares++; $display("FAIL req_flush got v=%b pc=%h occ=%0d exp 1/00004180/1", out_valid, out_pc, occupancy); end
    reset = 1'b1;
    step();
    reset = 1'b0; req = 1'b0;
    vectors++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_req got v=%b pc=%h occ=%0d exp 0/0/0", out_valid, out_pc, occupancy); end
  endtask

  task automatic test_noskid();
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_pc0 = 32'h4000; in_payload0 = pl(32'h4000);
    step();
    in_valid0 = 1'b0;
    vectors++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h4000 || occupancy0 !== 2'd1) begin miscompares++; $display("FAIL ns_load got v=%b pc=%h occ=%0d exp 1/4000/1", out_valid0, out_pc0, occupancy0); end
    vectors++; if (in_ready0 !== 1'b0) begin miscompares++; $display("FAIL ns_stall_ready got=%b exp=0", in_ready0); end
    step();
    vectors++; if (out_pc0 !== 32'h4000 || in_ready0 !== 1'b0) begin miscompares++; $display("FAIL ns_hold got pc=%h rdy=%b exp 4000/0", out_pc0, in_ready0); end
    out_ready0 = 1'b1;
    in_valid0 = 1'b1; in_pc0 = 32'h4004; in_payload0 = pl(32'h4004);
    #1;
    vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL ns_retire_ready got=%b exp=1", in_ready0); end
    step();
    in_valid0 = 1'b0;
    vectors++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h4004 || out_payload0 !== pl(32'h4004) || occupancy0 !== 2'd1) begin miscompares++; $display("FAIL ns_back_to_back got v=%b pc=%h occ=%0d exp 1/4004/1", out_valid0, out_pc0, occupancy0); end
    step();
    vectors++; if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0 || out_payload0 !== '0) begin miscompares++; $display("FAIL ns_drain got v=%b occ=%0d exp 0/0", out_valid0, occupancy0); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_exception();
    test_flush();
    test_simultaneous();
    test_noskid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
